// File: rtl/readout_counters_pkg.sv
// Shared constants and helpers for the CFEB readout counter core.
package readout_counters_pkg;

  // Walk order of the eight SCA samples within one block
  localparam logic [2:0] GRAY3_SEQ [8] = '{
    3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
  };

  function automatic logic [3:0] bin2gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Position of a Gray code within GRAY3_SEQ (reflected-Gray decode)
  function automatic logic [2:0] gray3_to_idx(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] gray3_next(input logic [2:0] g);
    logic [2:0] idx;
    idx = gray3_to_idx(g) + 3'd1;
    return GRAY3_SEQ[idx];
  endfunction

  function automatic logic [2:0] gray3_prev(input logic [2:0] g);
    logic [2:0] idx;
    idx = gray3_to_idx(g) - 3'd1;
    return GRAY3_SEQ[idx];
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/readout_counters_shift_dly.sv
// CE-gated delay line of DEPTH stages with synchronous clear and optional
// triplicated storage.
module shift_dly
  import readout_counters_pkg::*;
#(
  parameter int TMR   = 0,
  parameter int DEPTH = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic CLR,
  input  logic D,
  output logic Q
);

  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  logic [NCOPY-1:0][DEPTH-1:0] sr_copy_reg;
  logic [DEPTH-1:0]            sr_vote;
  logic [DEPTH-1:0]            sr_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (TMR != 0) begin : g_tmr
        assign sr_vote[gi] = maj3(sr_copy_reg[0][gi], sr_copy_reg[1][gi], sr_copy_reg[2][gi]);
      end else begin : g_single
        assign sr_vote[gi] = sr_copy_reg[0][gi];
      end
      // Stage 0 takes the input, every later stage takes its predecessor
      if (gi == 0) begin : g_head
        assign sr_next[gi] = CE ? D : sr_vote[gi];
      end else begin : g_body
        assign sr_next[gi] = CE ? sr_vote[gi-1] : sr_vote[gi];
      end
    end
  endgenerate

  // Every copy loads the voted next value so an upset copy reconverges
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCOPY; i++) begin
      if (!RST_N || CLR) begin
        sr_copy_reg[i] <= '0;
      end else begin
        sr_copy_reg[i] <= sr_next;
      end
    end
  end

  assign Q = sr_vote[DEPTH-1];

endmodule

// File: rtl/readout_counters.sv
// Channel Gray counter, bidirectional sample Gray counter and L1A delay line
// of the CFEB SCA readout sequencer.
module readout_counters
  import readout_counters_pkg::*;
#(
  parameter int TMR   = 0,
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       GC_CLR,
  input  logic       GC_CE,
  output logic [3:0] ADO,
  output logic [3:0] AD,
  output logic       TC,
  input  logic       START,
  input  logic       SMP_CE,
  input  logic       UPSIE,
  output logic [2:0] SAMP,
  input  logic       DLY_CE,
  input  logic       DLY_I,
  output logic       DLY_O
);

  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  logic [NCOPY-1:0][3:0] ad_copy_reg;
  logic [NCOPY-1:0][3:0] ado_copy_reg;
  logic [NCOPY-1:0][2:0] samp_copy_reg;

  logic [3:0] ad_vote, ado_vote, ad_next, ado_next;
  logic [2:0] samp_vote, samp_next;

  genvar gi;
  generate
    if (TMR != 0) begin : g_vote
      for (gi = 0; gi < 4; gi++) begin : g_ch
        assign ad_vote[gi]  = maj3(ad_copy_reg[0][gi], ad_copy_reg[1][gi], ad_copy_reg[2][gi]);
        assign ado_vote[gi] = maj3(ado_copy_reg[0][gi], ado_copy_reg[1][gi], ado_copy_reg[2][gi]);
      end
      for (gi = 0; gi < 3; gi++) begin : g_smp
        assign samp_vote[gi] = maj3(samp_copy_reg[0][gi], samp_copy_reg[1][gi], samp_copy_reg[2][gi]);
      end
    end else begin : g_novote
      assign ad_vote   = ad_copy_reg[0];
      assign ado_vote  = ado_copy_reg[0];
      assign samp_vote = samp_copy_reg[0];
    end
  endgenerate

  // Next-state for both counters: clear/load take priority over stepping
  always_comb begin
    ad_next = ad_vote;
    if (GC_CLR) begin
      ad_next = 4'd0;
    end else if (GC_CE) begin
      ad_next = ad_vote + 4'd1;
    end
    // Gray address is registered alongside AD so ADO never glitches
    ado_next = bin2gray4(ad_next);

    samp_next = samp_vote;
    if (START) begin
      samp_next = UPSIE ? 3'b000 : 3'b100;
    end else if (SMP_CE) begin
      samp_next = UPSIE ? gray3_next(samp_vote) : gray3_prev(samp_vote);
    end
  end

  // Counter register groups; each copy reloads from the voted next state
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCOPY; i++) begin
      if (!RST_N) begin
        ad_copy_reg[i]   <= 4'd0;
        ado_copy_reg[i]  <= 4'd0;
        samp_copy_reg[i] <= 3'b000;
      end else begin
        ad_copy_reg[i]   <= ad_next;
        ado_copy_reg[i]  <= ado_next;
        samp_copy_reg[i] <= samp_next;
      end
    end
  end

  assign AD   = ad_vote;
  assign ADO  = ado_vote;
  assign TC   = (ad_vote == 4'd15);
  assign SAMP = samp_vote;

  shift_dly #(
    .TMR   (TMR),
    .DEPTH (DEPTH)
  ) u_dly (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (DLY_CE),
    .CLR   (1'b0),
    .D     (DLY_I),
    .Q     (DLY_O)
  );

endmodule

// File: tb/tb_readout_counters.sv
// Directed bench for readout_counters: each step drives inputs, pushes the
// expected post-edge outputs to a scoreboard and compares after the edge.
module tb_readout_counters;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST_N, GC_CLR, GC_CE, START, SMP_CE, UPSIE, DLY_CE, DLY_I;
  logic [3:0] ADO, AD;
  logic       TC, DLY_O;
  logic [2:0] SAMP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] ad;
    logic [3:0] ado;
    logic       tc;
    logic [2:0] samp;
    logic       dlyo;
  } exp_t;

  exp_t sb_q[$];

  // Reference tables written out from the channel and sample sequences
  logic [3:0] ado_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [2:0] s_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

  int   m_ad   = 0;
  int   m_sidx = 0;
  logic dly_hist[$];

  readout_counters #(.TMR(1), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .GC_CLR (GC_CLR),
    .GC_CE  (GC_CE),
    .ADO    (ADO),
    .AD     (AD),
    .TC     (TC),
    .START  (START),
    .SMP_CE (SMP_CE),
    .UPSIE  (UPSIE),
    .SAMP   (SAMP),
    .DLY_CE (DLY_CE),
    .DLY_I  (DLY_I),
    .DLY_O  (DLY_O)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary (actual timeout, required finish)");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.ad   = 4'(m_ad);
    e.ado  = ado_tab[m_ad];
    e.tc   = (m_ad == 15);
    e.samp = s_tab[m_sidx];
    e.dlyo = dly_hist[DEPTH-1];
    return e;
  endfunction

  task automatic model_reset();
    m_ad   = 0;
    m_sidx = 0;
    dly_hist.delete();
    for (int i = 0; i < DEPTH; i++) dly_hist.push_back(1'b0);
  endtask

  task automatic step(input string tag, input logic rst_n, input logic gc_clr,
                      input logic gc_ce, input logic start, input logic smp_ce,
                      input logic upsie, input logic dly_ce, input logic dly_i);
    exp_t e;
    RST_N = rst_n; GC_CLR = gc_clr; GC_CE = gc_ce; START = start;
    SMP_CE = smp_ce; UPSIE = upsie; DLY_CE = dly_ce; DLY_I = dly_i;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (gc_clr) m_ad = 0;
      else if (gc_ce) m_ad = (m_ad + 1) % 16;
      if (start) m_sidx = upsie ? 0 : 7;
      else if (smp_ce) m_sidx = upsie ? (m_sidx + 1) % 8 : (m_sidx + 7) % 8;
      if (dly_ce) begin
        dly_hist.push_front(dly_i);
        void'(dly_hist.pop_back());
      end
    end
    sb_q.push_back(model_exp(tag));
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert ({AD, ADO, TC, SAMP, DLY_O} === {e.ad, e.ado, e.tc, e.samp, e.dlyo})
    else begin
      errors++;
      $error("FAIL %s: observed AD=%h ADO=%h TC=%b SAMP=%b DLY_O=%b expected AD=%h ADO=%h TC=%b SAMP=%b DLY_O=%b",
             e.tag, AD, ADO, TC, SAMP, DLY_O, e.ad, e.ado, e.tc, e.samp, e.dlyo);
    end
    $display("step %-10s AD=%h ADO=%h TC=%b SAMP=%b DLY_O=%b", e.tag, AD, ADO, TC, SAMP, DLY_O);
  endtask

  // Idle step with only the sample/delay controls of interest
  task automatic step_s(input string tag, input logic start, input logic smp_ce, input logic upsie);
    step(tag, 1'b1, 1'b0, 1'b0, start, smp_ce, upsie, 1'b0, 1'b0);
  endtask

  task automatic step_d(input string tag, input logic dly_ce, input logic dly_i);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dly_ce, dly_i);
  endtask

  initial begin
    logic [3:0] saved_ad;
    model_reset();
    @(negedge CLK);

    // Reset state, then idle
    step("reset", 1'b0, 0, 0, 0, 0, 1, 0, 0);
    step("idle", 1'b1, 0, 0, 0, 0, 1, 0, 0);

    // Full channel sweep 0..15..0
    for (int i = 0; i < 16; i++) step("ch_sweep", 1'b1, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step("ch_to7", 1'b1, 0, 1, 0, 0, 1, 0, 0);
    step("ch_clr", 1'b1, 1, 1, 0, 0, 1, 0, 0);
    step("ch_hold", 1'b1, 0, 0, 0, 0, 1, 0, 0);

    // Sample counter up block, down block, collisions and wraps
    step_s("smp_startU", 1, 0, 1);
    for (int i = 0; i < 8; i++) step_s("smp_up", 0, 1, 1);
    step_s("smp_startD", 1, 0, 0);
    for (int i = 0; i < 7; i++) step_s("smp_dn", 0, 1, 0);
    step_s("smp_wrapD", 0, 1, 0);
    step_s("smp_revU", 0, 1, 1);
    step_s("smp_st+ce", 1, 1, 1);
    step_s("smp_st+ceD", 1, 1, 0);

    // Delay line: single pulse with CE always high
    step_d("dly_in", 1, 1);
    for (int i = 0; i < 9; i++) step_d("dly_run", 1, 0);
    // Delay line: CE gated 1-of-2
    step_d("dly_g_in", 1, 1);
    for (int i = 0; i < 18; i++) step_d("dly_g_run", (i % 2) == 1, 0);

    // Load AD=9, SAMP=110, delay full of 1s, then reset mid-operation
    step("mid_load", 1'b1, 0, 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step("mid_load", 1'b1, 0, 1, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) step("mid_load", 1'b1, 0, 1, 0, 0, 1, 1, 1);
    step("mid_reset", 1'b0, 0, 1, 0, 1, 1, 1, 1);

    // TMR: upset one AD copy, outputs must not move and the copy must heal
    for (int i = 0; i < 5; i++) step("tmr_pre", 1'b1, 0, 1, 0, 0, 1, 0, 0);
    saved_ad = 4'(m_ad);
    @(negedge CLK);
    dut.ad_copy_reg[1] = ~saved_ad;
    #1;
    checks++;
    assert ({AD, ADO, TC} === {saved_ad, ado_tab[m_ad], 1'b0})
    else begin
      errors++;
      $error("FAIL tmr_mask: observed AD=%h ADO=%h TC=%b expected AD=%h ADO=%h TC=0",
             AD, ADO, TC, saved_ad, ado_tab[m_ad]);
    end
    $display("step tmr_mask   AD=%h ADO=%h TC=%b", AD, ADO, TC);
    step("tmr_next", 1'b1, 0, 1, 0, 0, 1, 0, 0);
    checks++;
    assert (dut.ad_copy_reg[1] === 4'(m_ad))
    else begin
      errors++;
      $error("FAIL tmr_heal: observed copy=%h expected %h", dut.ad_copy_reg[1], 4'(m_ad));
    end
    $display("step tmr_heal   copy1=%h", dut.ad_copy_reg[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
